class_argmax_unit: RTL and testbench
====================================

// Module: class_argmax_unit
// PURPOSE
//   Streaming argmax stage downstream of the per-class score path. It consumes one
//   SIZE-bit unsigned class score per handshake, in class order 0..NUM_CLASSES-1.
//   Each new score is compared against the running best using subtractor_lookahead.
//   After the frame ends, it presents the winning class label and its score to the
//   result consumer over a valid/ready handshake.
// PARAMETERS
//   SIZE         5   score width, unsigned; also the SIZE passed to subtractor_lookahead
//   NUM_CLASSES  10  scores per frame (digits 0-9); legal range 2..2**LABEL_W
//   LABEL_W      4   label / class-counter width
// PORTS
//   clk          in   1        single clock, rising edge
//   rst_n        in   1        asynchronous, active-low reset
//   score_valid  in   1        score_in / score_last valid this cycle
//   score_ready  out  1        block can accept a score
//   score_in     in   SIZE     class score, unsigned
//   score_last   in   1        marks the final score of the frame
//   label_valid  out  1        result valid; held until label_ready
//   label_ready  in   1        consumer accepts result
//   label_out    out  LABEL_W  index of the winning class
//   best_score   out  SIZE     score of the winning class
//   frame_err    out  1        frame length != NUM_CLASSES; valid with label_valid
// BEHAVIOUR
//   Reset (async assert, sync deassert): state=IDLE; score_ready=0 during reset,
//     then 1 in IDLE. label_valid=0; label_out, best_score, frame_err and cnt all 0.
//   Accept = score_valid & score_ready. Emit = label_valid & label_ready.
//   FSM:
//     IDLE: score_ready=1. On accept: best<=score_in, idx<=0, cnt<=1.
//       If score_last is also set, go to DONE with frame_err=1; else go to SCAN.
//     SCAN: score_ready=1. Per accept, compare best with score_in (rule below),
//       set cnt<=cnt+1, and update best/idx if the new score wins.
//       Frame end is score_last=1, or acceptance of class NUM_CLASSES-1, whichever is first.
//       At frame end go to DONE. Set frame_err=1 unless last arrived exactly at
//       cnt==NUM_CLASSES-1. A missing last is therefore still an error.
//     DONE: score_ready=0, label_valid=1. Outputs are stable until Emit.
//       On Emit: go to IDLE and clear label_valid and cnt.
//       No score is accepted in the Emit cycle; the next frame starts one cycle later.
//   Compare: instantiate subtractor_lookahead with input_1=best, input_2=score_in.
//     Its borrow_out is the carry of best + ~score_in + 1.
//     borrow_out==0 means score_in > best: take the new score (best<=score_in, idx<=cnt).
//     borrow_out==1 means score_in <= best: keep best.
//     On ties the lower class index wins. The difference output is unused.
//   Latency: label_valid rises on the clock edge that accepts the frame-ending score.
//     The result is visible the next cycle. Throughput is one score/cycle within a frame.
//   Counter: cnt never wraps. Frame end is forced at NUM_CLASSES-1, so cnt <= NUM_CLASSES-1.
//   Reset mid-frame or mid-DONE: the partial frame and any pending result are
//     discarded; the block returns to IDLE.
//   label_ready while label_valid=0 is ignored. score_valid while in DONE is ignored
//     and is stalled by score_ready=0.
// TESTING
//   1. Scores 3,7,2,31,0,5,9,1,4,6 with last on class 9 -> label_out=3,
//      best_score=31, frame_err=0, label_valid one cycle after the last accept.
//   2. All-equal scores 12 x10 -> label_out=0, best_score=12 (tie keeps lowest index).
//   3. Scores 0..9 ascending, label_ready held low 5 cycles -> label_out=9 and
//      best_score=9 stable, score_ready=0 throughout; frame 2 accepted 1 cycle after Emit.
//   4. last asserted on the 6th score (scores 1,2,8,4,3,0) -> label_out=2,
//      best_score=8, frame_err=1.
//   5. 10 scores with no last -> frame ends at class 9 with frame_err=1. An 11th
//      score_valid is stalled until Emit.
//   6. rst_n pulsed low mid-frame after 4 scores, then a clean frame of 5s with
//      class 7 = 20 -> label_out=7, best_score=20, frame_err=0.

Source files
------------

// File: rtl/class_argmax_if.sv
// Score-in / label-out handshake bundle for the class argmax stage.
// master = score producer and result consumer, slave = argmax unit.
interface class_argmax_if #(
   parameter int SIZE    = 5,
   parameter int LABEL_W = 4
);
   logic               score_valid;
   logic               score_ready;
   logic [SIZE-1:0]    score_in;
   logic               score_last;
   logic               label_valid;
   logic               label_ready;
   logic [LABEL_W-1:0] label_out;
   logic [SIZE-1:0]    best_score;
   logic               frame_err;

   modport master (
      output score_valid, score_in, score_last, label_ready,
      input  score_ready, label_valid, label_out, best_score, frame_err
   );

   modport slave (
      input  score_valid, score_in, score_last, label_ready,
      output score_ready, label_valid, label_out, best_score, frame_err
   );
endinterface

// File: rtl/class_argmax_unit.sv
// Streaming argmax over one frame of NUM_CLASSES unsigned scores.
// Running best is compared against each incoming score with a
// carry-lookahead subtractor; the winner is offered on a valid/ready port.

// Carry-lookahead subtractor: input_1 - input_2 as input_1 + ~input_2 + 1.
// borrow_out is the raw carry-out (1 means input_1 >= input_2).
module subtractor_lookahead #(
   parameter int SIZE = 5
) (
   input  logic [SIZE-1:0] input_1,
   input  logic [SIZE-1:0] input_2,
   output logic [SIZE-1:0] difference,
   output logic            borrow_out
);
   logic [SIZE-1:0] g;
   logic [SIZE-1:0] p;
   logic [SIZE:0]   c;
   logic            pp;

   // Each carry is expanded as a flat generate/propagate sum of products.
   always_comb begin
      g    = input_1 & ~input_2;
      p    = input_1 ^ ~input_2;
      c    = '0;
      c[0] = 1'b1;
      pp   = 1'b0;
      for (int i = 0; i < SIZE; i++) begin
         c[i+1] = g[i];
         pp     = p[i];
         for (int j = i - 1; j >= 0; j--) begin
            c[i+1] = c[i+1] | (pp & g[j]);
            pp     = pp & p[j];
         end
         c[i+1] = c[i+1] | (pp & c[0]);
      end
      difference = p ^ c[SIZE-1:0];
      borrow_out = c[SIZE];
   end
endmodule

module class_argmax_unit #(
   parameter int SIZE        = 5,
   parameter int NUM_CLASSES = 10,
   parameter int LABEL_W     = 4
) (
   input  logic           clk,
   input  logic           rst_n,
   class_argmax_if.slave  bus
);
   typedef enum logic [1:0] {IDLE, SCAN, DONE} state_t;

   localparam logic [LABEL_W-1:0] LAST_IDX = LABEL_W'(NUM_CLASSES - 1);

   state_t             state, state_nxt;
   logic [SIZE-1:0]    best;
   logic [LABEL_W-1:0] idx;
   logic [LABEL_W-1:0] cnt;
   logic               err;
   logic               rdy_en;
   logic               accept;
   logic               emit;
   logic               frame_end;
   logic               borrow;
   logic [SIZE-1:0]    diff_unused;

   // best - score_in; no carry-out means the new score is strictly larger,
   // so ties keep the earlier (lower) class index.
   subtractor_lookahead #(.SIZE(SIZE)) u_cmp (
      .input_1    (best),
      .input_2    (bus.score_in),
      .difference (diff_unused),
      .borrow_out (borrow)
   );

   assign accept    = bus.score_valid & bus.score_ready;
   assign emit      = bus.label_valid & bus.label_ready;
   assign frame_end = bus.score_last | (cnt == LAST_IDX);

   // Holds score_ready low through reset and releases it on the first edge after.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) rdy_en <= 1'b0;
      else        rdy_en <= 1'b1;
   end

   // State register.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) state <= IDLE;
      else        state <= state_nxt;
   end

   // Next-state logic.
   always_comb begin
      state_nxt = state;
      case (state)
         IDLE: if (accept) state_nxt = bus.score_last ? DONE : SCAN;
         SCAN: if (accept && frame_end) state_nxt = DONE;
         DONE: if (emit) state_nxt = IDLE;
         default: state_nxt = IDLE;
      endcase
   end

   // Handshake outputs decoded from state.
   always_comb begin
      bus.score_ready = rdy_en & (state != DONE);
      bus.label_valid = (state == DONE);
   end

   // Running best / index / class counter / frame error.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         best <= '0;
         idx  <= '0;
         cnt  <= '0;
         err  <= 1'b0;
      end else begin
         case (state)
            IDLE: if (accept) begin
               best <= bus.score_in;
               idx  <= '0;
               cnt  <= LABEL_W'(1);
               err  <= bus.score_last;
            end
            SCAN: if (accept) begin
               if (!borrow) begin
                  best <= bus.score_in;
                  idx  <= cnt;
               end
               // Counter stops at the frame-ending class so it cannot wrap
               // when NUM_CLASSES == 2**LABEL_W.
               if (frame_end) err <= !(bus.score_last && (cnt == LAST_IDX));
               else           cnt <= cnt + LABEL_W'(1);
            end
            DONE: if (emit) cnt <= '0;
            default: ;
         endcase
      end
   end

   assign bus.label_out  = idx;
   assign bus.best_score = best;
   assign bus.frame_err  = err;
endmodule

// File: tb/tb_class_argmax_unit.sv
// Directed bench for class_argmax_unit: one task per scenario, inline checks.
module tb_class_argmax_unit;
   logic clk = 1'b0;
   logic rst_n = 1'b0;
   int   tests = 0;
   int   fails = 0;
   int   sc[12];

   class_argmax_if #(.SIZE(5), .LABEL_W(4)) bus ();

   class_argmax_unit #(.SIZE(5), .NUM_CLASSES(10), .LABEL_W(4)) dut (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (bus)
   );

   always #5 clk = ~clk;

   // Present one score and hold it until accepted (bounded); returns #1 after the accepting edge.
   task automatic send(input int s, input bit last);
      int n = 0;
      @(negedge clk);
      bus.score_valid = 1'b1;
      bus.score_in    = 5'(s);
      bus.score_last  = last;
      while (!bus.score_ready && n < 20) begin
         @(negedge clk);
         n++;
      end
      tests++;
      if (!bus.score_ready) begin
         fails++;
         $display("FAIL send_timeout: score_ready=%b after %0d cycles, required 1", bus.score_ready, n);
      end
      @(posedge clk);
      #1;
      bus.score_valid = 1'b0;
      bus.score_last  = 1'b0;
   endtask

   // Send sc[0..n-1]; last flagged on index last_at (-1 = never).
   task automatic send_frame(input int n, input int last_at);
      for (int i = 0; i < n; i++) send(sc[i], i == last_at);
   endtask

   // Wait (bounded) for label_valid, then take the result with a one-cycle label_ready.
   task automatic take_result();
      int n = 0;
      while (!bus.label_valid && n < 20) begin
         @(negedge clk);
         n++;
      end
      tests++;
      if (!bus.label_valid) begin
         fails++;
         $display("FAIL label_timeout: label_valid=%b, required 1", bus.label_valid);
      end
      @(negedge clk);
      bus.label_ready = 1'b1;
      @(posedge clk);
      #1;
      bus.label_ready = 1'b0;
   endtask

   task automatic test_reset();
      bus.score_valid = 1'b0;
      bus.score_in    = '0;
      bus.score_last  = 1'b0;
      bus.label_ready = 1'b0;
      rst_n = 1'b0;
      repeat (2) @(negedge clk);
      tests += 5;
      if (bus.score_ready !== 1'b0) begin fails++; $display("FAIL rst_ready: got %b exp 0", bus.score_ready); end
      if (bus.label_valid !== 1'b0) begin fails++; $display("FAIL rst_valid: got %b exp 0", bus.label_valid); end
      if (bus.label_out !== 4'd0)   begin fails++; $display("FAIL rst_label: got %0d exp 0", bus.label_out); end
      if (bus.best_score !== 5'd0)  begin fails++; $display("FAIL rst_best: got %0d exp 0", bus.best_score); end
      if (bus.frame_err !== 1'b0)   begin fails++; $display("FAIL rst_err: got %b exp 0", bus.frame_err); end
      rst_n = 1'b1;
      // label_ready with no result pending must be ignored
      bus.label_ready = 1'b1;
      repeat (2) @(negedge clk);
      bus.label_ready = 1'b0;
      tests += 2;
      if (bus.score_ready !== 1'b1) begin fails++; $display("FAIL idle_ready: got %b exp 1", bus.score_ready); end
      if (bus.label_valid !== 1'b0) begin fails++; $display("FAIL idle_valid: got %b exp 0", bus.label_valid); end
   endtask

   task automatic test_basic();
      sc = '{3, 7, 2, 31, 0, 5, 9, 1, 4, 6, 0, 0};
      send_frame(9, -1);
      tests++;
      if (bus.label_valid !== 1'b0) begin fails++; $display("FAIL basic_early_valid: got %b exp 0", bus.label_valid); end
      send(sc[9], 1'b1);
      tests += 5;
      if (bus.label_valid !== 1'b1) begin fails++; $display("FAIL basic_latency: got %b exp 1", bus.label_valid); end
      if (bus.score_ready !== 1'b0) begin fails++; $display("FAIL basic_ready: got %b exp 0", bus.score_ready); end
      if (bus.label_out !== 4'd3)   begin fails++; $display("FAIL basic_label: got %0d exp 3", bus.label_out); end
      if (bus.best_score !== 5'd31) begin fails++; $display("FAIL basic_best: got %0d exp 31", bus.best_score); end
      if (bus.frame_err !== 1'b0)   begin fails++; $display("FAIL basic_err: got %b exp 0", bus.frame_err); end
      take_result();
   endtask

   task automatic test_ties();
      sc = '{12, 12, 12, 12, 12, 12, 12, 12, 12, 12, 0, 0};
      send_frame(10, 9);
      tests += 3;
      if (bus.label_out !== 4'd0)   begin fails++; $display("FAIL tie_label: got %0d exp 0", bus.label_out); end
      if (bus.best_score !== 5'd12) begin fails++; $display("FAIL tie_best: got %0d exp 12", bus.best_score); end
      if (bus.frame_err !== 1'b0)   begin fails++; $display("FAIL tie_err: got %b exp 0", bus.frame_err); end
      take_result();
   endtask

   task automatic test_backpressure();
      sc = '{0, 1, 2, 3, 4, 5, 6, 7, 8, 9, 0, 0};
      send_frame(10, 9);
      for (int k = 0; k < 5; k++) begin
         @(negedge clk);
         tests += 4;
         if (bus.label_valid !== 1'b1) begin fails++; $display("FAIL bp_valid[%0d]: got %b exp 1", k, bus.label_valid); end
         if (bus.score_ready !== 1'b0) begin fails++; $display("FAIL bp_ready[%0d]: got %b exp 0", k, bus.score_ready); end
         if (bus.label_out !== 4'd9)   begin fails++; $display("FAIL bp_label[%0d]: got %0d exp 9", k, bus.label_out); end
         if (bus.best_score !== 5'd9)  begin fails++; $display("FAIL bp_best[%0d]: got %0d exp 9", k, bus.best_score); end
      end
      take_result();
      tests += 2;
      if (bus.label_valid !== 1'b0) begin fails++; $display("FAIL bp_emit_valid: got %b exp 0", bus.label_valid); end
      if (bus.score_ready !== 1'b1) begin fails++; $display("FAIL bp_emit_ready: got %b exp 1", bus.score_ready); end
      sc = '{10, 9, 8, 7, 6, 5, 4, 3, 2, 1, 0, 0};
      send_frame(10, 9);
      tests += 3;
      if (bus.label_out !== 4'd0)   begin fails++; $display("FAIL f2_label: got %0d exp 0", bus.label_out); end
      if (bus.best_score !== 5'd10) begin fails++; $display("FAIL f2_best: got %0d exp 10", bus.best_score); end
      if (bus.frame_err !== 1'b0)   begin fails++; $display("FAIL f2_err: got %b exp 0", bus.frame_err); end
      take_result();
   endtask

   task automatic test_short_frame();
      sc = '{1, 2, 8, 4, 3, 0, 0, 0, 0, 0, 0, 0};
      send_frame(6, 5);
      tests += 4;
      if (bus.label_valid !== 1'b1) begin fails++; $display("FAIL short_valid: got %b exp 1", bus.label_valid); end
      if (bus.label_out !== 4'd2)   begin fails++; $display("FAIL short_label: got %0d exp 2", bus.label_out); end
      if (bus.best_score !== 5'd8)  begin fails++; $display("FAIL short_best: got %0d exp 8", bus.best_score); end
      if (bus.frame_err !== 1'b1)   begin fails++; $display("FAIL short_err: got %b exp 1", bus.frame_err); end
      take_result();
   endtask

   task automatic test_missing_last();
      sc = '{5, 17, 3, 17, 0, 1, 2, 3, 4, 6, 0, 0};
      send_frame(10, -1);
      tests += 4;
      if (bus.label_valid !== 1'b1) begin fails++; $display("FAIL nolast_valid: got %b exp 1", bus.label_valid); end
      if (bus.label_out !== 4'd1)   begin fails++; $display("FAIL nolast_label: got %0d exp 1", bus.label_out); end
      if (bus.best_score !== 5'd17) begin fails++; $display("FAIL nolast_best: got %0d exp 17", bus.best_score); end
      if (bus.frame_err !== 1'b1)   begin fails++; $display("FAIL nolast_err: got %b exp 1", bus.frame_err); end
      // 11th score is held off until the result is taken
      @(negedge clk);
      bus.score_valid = 1'b1;
      bus.score_in    = 5'd7;
      bus.score_last  = 1'b0;
      for (int k = 0; k < 3; k++) begin
         @(negedge clk);
         tests += 2;
         if (bus.score_ready !== 1'b0) begin fails++; $display("FAIL stall_ready[%0d]: got %b exp 0", k, bus.score_ready); end
         if (bus.best_score !== 5'd17) begin fails++; $display("FAIL stall_best[%0d]: got %0d exp 17", k, bus.best_score); end
      end
      bus.label_ready = 1'b1;
      @(posedge clk);
      #1;
      bus.label_ready = 1'b0;
      tests++;
      if (bus.score_ready !== 1'b1) begin fails++; $display("FAIL stall_release: got %b exp 1", bus.score_ready); end
      @(posedge clk);
      #1;
      bus.score_valid = 1'b0;
      sc = '{0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0};
      send_frame(9, 8);
      tests += 3;
      if (bus.label_out !== 4'd0)   begin fails++; $display("FAIL resume_label: got %0d exp 0", bus.label_out); end
      if (bus.best_score !== 5'd7)  begin fails++; $display("FAIL resume_best: got %0d exp 7", bus.best_score); end
      if (bus.frame_err !== 1'b0)   begin fails++; $display("FAIL resume_err: got %b exp 0", bus.frame_err); end
      take_result();
   endtask

   task automatic test_mid_reset();
      sc = '{25, 30, 2, 1, 0, 0, 0, 0, 0, 0, 0, 0};
      send_frame(4, -1);
      #2;
      rst_n = 1'b0;
      #1;
      tests += 3;
      if (bus.score_ready !== 1'b0) begin fails++; $display("FAIL mrst_ready: got %b exp 0", bus.score_ready); end
      if (bus.label_valid !== 1'b0) begin fails++; $display("FAIL mrst_valid: got %b exp 0", bus.label_valid); end
      if (bus.best_score !== 5'd0)  begin fails++; $display("FAIL mrst_best: got %0d exp 0", bus.best_score); end
      repeat (2) @(negedge clk);
      rst_n = 1'b1;
      sc = '{5, 5, 5, 5, 5, 5, 5, 20, 5, 5, 0, 0};
      send_frame(10, 9);
      tests += 4;
      if (bus.label_valid !== 1'b1) begin fails++; $display("FAIL clean_valid: got %b exp 1", bus.label_valid); end
      if (bus.label_out !== 4'd7)   begin fails++; $display("FAIL clean_label: got %0d exp 7", bus.label_out); end
      if (bus.best_score !== 5'd20) begin fails++; $display("FAIL clean_best: got %0d exp 20", bus.best_score); end
      if (bus.frame_err !== 1'b0)   begin fails++; $display("FAIL clean_err: got %b exp 0", bus.frame_err); end
      take_result();
   endtask

   initial begin
      test_reset();
      test_basic();
      test_ties();
      test_backpressure();
      test_short_frame();
      test_missing_last();
      test_mid_reset();
      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end
endmodule
